// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, its byte-wide instruction ROM and the instruction consumer.
// The master modport is the sequencer side; the slave modport is the ROM/consumer/control side.
interface fetch_sequencer_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                     fetch_en;
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     mem_en;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [7:0]               mem_rdata;
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] instr_pc;
    logic                     instr_valid;
    logic                     instr_ready;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, mem_rdata, instr_ready,
        output mem_en, mem_addr, instr, instr_pc, instr_valid
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, mem_rdata, instr_ready,
        input  mem_en, mem_addr, instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Assembles 32-bit little-endian instructions from a byte-wide combinational ROM, one byte per
// enabled cycle, then holds the result until the consumer accepts it or a redirect arrives.
module fetch_sequencer #(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic clk,
    input  logic rst_n,
    fetch_sequencer_if.master bus
);
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } seqState_t;

    seqState_t                stateR,      stateNextS;
    logic [1:0]               cntR,        cntNextS;
    logic [ADDRESS_WIDTH-1:0] pcR,         pcNextS;
    logic [DATA_WIDTH-1:0]    instrR,      instrNextS;
    logic [ADDRESS_WIDTH-1:0] instrPcR,    instrPcNextS;
    logic                     instrValidR, instrValidNextS;
    logic                     memEnS;

    // rst_n gates the strobe so no ROM read is issued while reset is held
    assign memEnS       = (stateR == FETCH) && bus.fetch_en && rst_n;
    assign bus.mem_en   = memEnS;
    assign bus.mem_addr = pcR + ADDRESS_WIDTH'(cntR);

    assign bus.instr       = instrR;
    assign bus.instr_pc    = instrPcR;
    assign bus.instr_valid = instrValidR;

    // State register for the sequencer and its captured instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR      <= FETCH;
            cntR        <= 2'd0;
            pcR         <= RESET_PC;
            instrR      <= '0;
            instrPcR    <= RESET_PC;
            instrValidR <= 1'b0;
        end else begin
            stateR      <= stateNextS;
            cntR        <= cntNextS;
            pcR         <= pcNextS;
            instrR      <= instrNextS;
            instrPcR    <= instrPcNextS;
            instrValidR <= instrValidNextS;
        end
    end

    // Next-state logic; a redirect overrides everything, including a same-cycle handshake
    always_comb begin
        stateNextS      = stateR;
        cntNextS        = cntR;
        pcNextS         = pcR;
        instrNextS      = instrR;
        instrPcNextS    = instrPcR;
        instrValidNextS = instrValidR;

        if (bus.redirect_valid) begin
            stateNextS      = FETCH;
            cntNextS        = 2'd0;
            pcNextS         = bus.redirect_pc;
            instrValidNextS = 1'b0;
        end else begin
            case (stateR)
                FETCH: begin
                    if (memEnS) begin
                        case (cntR)
                            2'd0:    instrNextS[7:0]   = bus.mem_rdata;
                            2'd1:    instrNextS[15:8]  = bus.mem_rdata;
                            2'd2:    instrNextS[23:16] = bus.mem_rdata;
                            2'd3:    instrNextS[31:24] = bus.mem_rdata;
                            default: instrNextS        = instrR;
                        endcase
                        // Counter wraps 3 -> 0, so HOLD starts with mem_addr back at pc
                        cntNextS = cntR + 2'd1;
                        if (cntR == 2'd3) begin
                            stateNextS      = HOLD;
                            instrValidNextS = 1'b1;
                            instrPcNextS    = pcR;
                        end else begin
                            stateNextS = FETCH;
                        end
                    end else begin
                        cntNextS = cntR;
                    end
                end
                HOLD: begin
                    if (instrValidR && bus.instr_ready) begin
                        stateNextS      = FETCH;
                        cntNextS        = 2'd0;
                        pcNextS         = pcR + ADDRESS_WIDTH'(3'd4);
                        instrValidNextS = 1'b0;
                    end else begin
                        stateNextS = HOLD;
                    end
                end
                default: begin
                    stateNextS      = FETCH;
                    cntNextS        = 2'd0;
                    instrValidNextS = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: byte ROM model, hand-computed addresses and instructions.
module tb_fetch_sequencer;
    logic clk;
    logic rst_n;
    logic [7:0] rom [0:65535];
    int totalCnt = 0;
    int badCnt   = 0;
    logic [5:0] patEn;
    int expAddr [6] = '{0, 1, 1, 1, 2, 3};

    fetch_sequencer_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus ();

    fetch_sequencer #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_rdata = rom[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.instr_ready    = 1'b0;
        patEn              = 6'b111001;
        for (int i = 0; i < 65536; i++) rom[i] = 8'(i) ^ 8'hA5;
        rom[16'h0000] = 8'h13; rom[16'h0001] = 8'h05; rom[16'h0002] = 8'h50; rom[16'h0003] = 8'h00;
        rom[16'h0004] = 8'h93; rom[16'h0005] = 8'h00; rom[16'h0006] = 8'h10; rom[16'h0007] = 8'h00;
        rom[16'h0040] = 8'h11; rom[16'h0041] = 8'h22; rom[16'h0042] = 8'h33; rom[16'h0043] = 8'h44;
        rom[16'hFFFE] = 8'hAA; rom[16'hFFFF] = 8'hBB;

        // reset state
        #2;
        checkVal("rst_mem_en",   32'(bus.mem_en),      32'h0);
        checkVal("rst_valid",    32'(bus.instr_valid), 32'h0);
        checkVal("rst_instr",    32'(bus.instr),       32'h0);
        checkVal("rst_instr_pc", 32'(bus.instr_pc),    32'h0);
        checkVal("rst_addr",     32'(bus.mem_addr),    32'h0);
        repeat (2) @(posedge clk);

        // basic fetch of 0x00500513 with ready held high
        @(negedge clk);
        rst_n = 1'b1; bus.fetch_en = 1'b1; bus.instr_ready = 1'b1;
        #1;
        checkVal("f0_mem_en", 32'(bus.mem_en),   32'h1);
        checkVal("f0_addr",   32'(bus.mem_addr), 32'h0);
        tick(); checkVal("f1_addr", 32'(bus.mem_addr), 32'h1);
        tick(); checkVal("f2_addr", 32'(bus.mem_addr), 32'h2);
        tick(); checkVal("f3_addr", 32'(bus.mem_addr), 32'h3);
        checkVal("f3_valid", 32'(bus.instr_valid), 32'h0);
        tick();
        checkVal("f_valid",    32'(bus.instr_valid), 32'h1);
        checkVal("f_instr",    32'(bus.instr),       32'h00500513);
        checkVal("f_instr_pc", 32'(bus.instr_pc),    32'h0);
        checkVal("f_hold_en",  32'(bus.mem_en),      32'h0);
        tick();
        checkVal("hs_valid",  32'(bus.instr_valid), 32'h0);
        checkVal("hs_addr",   32'(bus.mem_addr),    32'h4);
        checkVal("hs_mem_en", 32'(bus.mem_en),      32'h1);

        // back-pressure: hold instruction at 0x0004 for 10 cycles
        bus.instr_ready = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 10; i++) begin
            checkVal("bp_valid",    32'(bus.instr_valid), 32'h1);
            checkVal("bp_instr",    32'(bus.instr),       32'h00100093);
            checkVal("bp_instr_pc", 32'(bus.instr_pc),    32'h4);
            checkVal("bp_mem_en",   32'(bus.mem_en),      32'h0);
            tick();
        end
        bus.instr_ready = 1'b1;
        tick();
        checkVal("bp_rel_valid", 32'(bus.instr_valid), 32'h0);
        checkVal("bp_rel_addr",  32'(bus.mem_addr),    32'h8);

        // redirect while cnt=2
        tick(); tick();
        checkVal("rd_pre_addr", 32'(bus.mem_addr), 32'hA);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0040;
        tick();
        bus.redirect_valid = 1'b0;
        checkVal("rd_addr",  32'(bus.mem_addr),    32'h40);
        checkVal("rd_valid", 32'(bus.instr_valid), 32'h0);
        repeat (4) tick();
        checkVal("rd_instr_valid", 32'(bus.instr_valid), 32'h1);
        checkVal("rd_instr",       32'(bus.instr),       32'h44332211);
        checkVal("rd_instr_pc",    32'(bus.instr_pc),    32'h40);

        // redirect coinciding with handshake, unaligned target that wraps
        rom[16'h0000] = 8'hCC; rom[16'h0001] = 8'hDD;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 16'hFFFE;
        tick();
        bus.redirect_valid = 1'b0;
        checkVal("wr_addr0", 32'(bus.mem_addr),    32'hFFFE);
        checkVal("wr_valid", 32'(bus.instr_valid), 32'h0);
        tick(); checkVal("wr_addr1", 32'(bus.mem_addr), 32'hFFFF);
        tick(); checkVal("wr_addr2", 32'(bus.mem_addr), 32'h0000);
        tick(); checkVal("wr_addr3", 32'(bus.mem_addr), 32'h0001);
        tick();
        checkVal("wr_instr",    32'(bus.instr),    32'hDDCCBBAA);
        checkVal("wr_instr_pc", 32'(bus.instr_pc), 32'hFFFE);
        tick();
        checkVal("wr_next_addr", 32'(bus.mem_addr), 32'h0002);

        // redirect taken while fetch_en is low
        bus.fetch_en = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0100;
        #1;
        checkVal("st_mem_en", 32'(bus.mem_en), 32'h0);
        tick();
        bus.redirect_valid = 1'b0;
        checkVal("st_rd_addr",  32'(bus.mem_addr),    32'h0100);
        checkVal("st_rd_valid", 32'(bus.instr_valid), 32'h0);
        rom[16'h0000] = 8'h13; rom[16'h0001] = 8'h05;

        // fetch_en pattern 1,0,0,1,1,1 from reset
        bus.instr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("pr_mem_en", 32'(bus.mem_en), 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) rst_n = 1'b1;
            bus.fetch_en = patEn[k];
            #1;
            checkVal("pt_mem_en", 32'(bus.mem_en),      32'(patEn[k]));
            checkVal("pt_addr",   32'(bus.mem_addr),    32'(expAddr[k]));
            checkVal("pt_valid",  32'(bus.instr_valid), 32'h0);
        end
        tick();
        checkVal("pt_done_valid", 32'(bus.instr_valid), 32'h1);
        checkVal("pt_done_instr", 32'(bus.instr),       32'h00500513);
        checkVal("pt_done_pc",    32'(bus.instr_pc),    32'h0);

        // async reset while holding a valid instruction
        tick();
        checkVal("hr_pre_valid", 32'(bus.instr_valid), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("hr_valid",    32'(bus.instr_valid), 32'h0);
        checkVal("hr_instr",    32'(bus.instr),       32'h0);
        checkVal("hr_instr_pc", 32'(bus.instr_pc),    32'h0);
        checkVal("hr_mem_en",   32'(bus.mem_en),      32'h0);
        @(negedge clk);
        rst_n = 1'b1; bus.fetch_en = 1'b1;
        #1;
        checkVal("hr_rel_addr",  32'(bus.mem_addr), 32'h0);
        checkVal("hr_rel_mem_en", 32'(bus.mem_en),  32'h1);
        tick(); checkVal("hr_addr1", 32'(bus.mem_addr), 32'h1);
        tick(); checkVal("hr_addr2", 32'(bus.mem_addr), 32'h2);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end
endmodule
